// File: rtl/reg_bank_cmp_pkg.sv
// Shared state encoding for the register-bank compare/scan controller.
package reg_bank_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_mag_nb.sv
// Combinational magnitude comparator, a relative to b.
// Signed ordering when REG_BANK_CMP_SIGNED_EN is defined, unsigned otherwise.
module cmp_mag_nb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

`ifdef REG_BANK_CMP_SIGNED_EN
    assign lt = ($signed(a) < $signed(b));
`else
    assign lt = (a < b);
`endif
    assign eq = (a == b);
    assign gt = ~lt & ~eq;

endmodule

// File: rtl/reg_bank_cmp.sv
// Register bank with a pairwise compare and a linear minimum scan.
// Ordering is signed when REG_BANK_CMP_SIGNED_EN is defined (see cmp_mag_nb).
//
// state | meaning
// IDLE  | waiting for cmp_go / scan_go
// CMP   | two cycles: capture operands, then register lt/eq/gt
// SCAN  | walk r[1..DEPTH-1] keeping the strict running minimum
// DONE  | results valid for one cycle, back to IDLE
module reg_bank_cmp
    import reg_bank_cmp_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [DEPTH-1:0] ld,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    sel_a,
    input  logic [AW-1:0]    sel_b,
    input  logic             cmp_go,
    input  logic             scan_go,
    output logic             busy,
    output logic             valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [AW-1:0]    min_idx,
    output logic [WIDTH-1:0] min_val
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] r [DEPTH];
    logic [AW-1:0]    sel_a_q, sel_b_q;
    logic             cmp_ph_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [AW-1:0]    idx_q, run_idx_q;
    logic [WIDTH-1:0] run_min_q;
    logic [WIDTH-1:0] cur_val;
    logic             c_lt, c_eq, c_gt;
    logic             s_lt, s_eq, s_gt;
    logic             s_take;
    logic             scan_last;

    assign cur_val   = r[idx_q];
    assign s_take    = s_lt & ~(s_eq | s_gt);
    assign scan_last = (idx_q == AW'(DEPTH - 1));

    cmp_mag_nb #(.WIDTH(WIDTH)) u_cmp_ab (
        .a  (opa_q),
        .b  (opb_q),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    cmp_mag_nb #(.WIDTH(WIDTH)) u_cmp_scan (
        .a  (cur_val),
        .b  (run_min_q),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        valid   = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (cmp_go)       state_d = ST_CMP;
                else if (scan_go) state_d = ST_SCAN;
            end
            ST_CMP:  if (cmp_ph_q)  state_d = ST_DONE;
            ST_SCAN: if (scan_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) r[i] <= '0;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            cmp_ph_q  <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            idx_q     <= '0;
            run_idx_q <= '0;
            run_min_q <= '0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            min_idx   <= '0;
            min_val   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld[i]) r[i] <= din;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmp_go) begin
                        sel_a_q  <= sel_a;
                        sel_b_q  <= sel_b;
                        cmp_ph_q <= 1'b0;
                    end else if (scan_go) begin
                        run_min_q <= r[0];
                        run_idx_q <= '0;
                        idx_q     <= AW'(1);
                    end
                end
                ST_CMP: begin
                    // Operands are captured first so the comparator sees stable values.
                    if (!cmp_ph_q) begin
                        opa_q    <= r[sel_a_q];
                        opb_q    <= r[sel_b_q];
                        cmp_ph_q <= 1'b1;
                    end else begin
                        lt <= c_lt;
                        eq <= c_eq;
                        gt <= c_gt;
                    end
                end
                ST_SCAN: begin
                    if (s_take) begin
                        run_min_q <= cur_val;
                        run_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + AW'(1);
                    if (scan_last) begin
                        min_idx <= s_take ? idx_q   : run_idx_q;
                        min_val <= s_take ? cur_val : run_min_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
